// File: rtl/flo_pkg.sv
// ---------------------------------------------------------------------------
// flo_pkg
// Shared definitions for the flobuffer dispatcher. Holds the bit positions of
// the 32-bit instruction word and the widths of the buses that fan out to
// the flobuffer channels.
//
// Instruction word layout:
//   [31:28] dest    target channel index
//   [27]    direct  1 = direct-write strobe, 0 = FIFO-write strobe
//   [26:23] rsvd    reserved, must be zero
//   [22:16] delay   delay value forwarded on delay_o
//   [15:0]  data    payload forwarded on data_o
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package flo_pkg;

  localparam int WORD_W  = 32;
  localparam int DATA_W  = 16;
  localparam int DELAY_W = 7;
  localparam int DEST_W  = 4;
  localparam int RSVD_W  = 4;

  localparam int DEST_MSB   = 31;
  localparam int DEST_LSB   = 28;
  localparam int DIRECT_BIT = 27;
  localparam int RSVD_MSB   = 26;
  localparam int RSVD_LSB   = 23;
  localparam int DELAY_MSB  = 22;
  localparam int DELAY_LSB  = 16;
  localparam int DATA_MSB   = 15;
  localparam int DATA_LSB   = 0;

endpackage : flo_pkg

// File: rtl/flo_dispatch.sv
// ---------------------------------------------------------------------------
// flo_dispatch
// Accepts instruction words from an upstream valid/ready source, holds one
// word at a time and issues it to one of N_BUF flobuffer channels as either a
// FIFO-write strobe (valid_o) or a direct-write strobe (direct_o). Malformed
// words (dest out of range or reserved bits set) are dropped with err_o.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   enable_i      1 = issuing/accepting permitted
//   in_data_i     32-bit instruction word
//   in_valid_i    upstream word present
//   in_ready_o    dispatcher can accept this cycle
//   full_i        per-channel flobuffer full flags
//   data_o        shared data bus (holds last issued value)
//   delay_o       shared delay bus (holds last issued value)
//   valid_o       one-hot, one-cycle FIFO-write strobe
//   direct_o      one-hot, one-cycle direct-write strobe
//   err_o         one-cycle strobe when a word is dropped
//   issued_cnt_o  wrapping count of issued words
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module flo_dispatch
  import flo_pkg::*;
#(
  parameter int N_BUF = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [WORD_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [N_BUF-1:0]   full_i,
  output logic [DATA_W-1:0]  data_o,
  output logic [DELAY_W-1:0] delay_o,
  output logic [N_BUF-1:0]   valid_o,
  output logic [N_BUF-1:0]   direct_o,
  output logic               err_o,
  output logic [31:0]        issued_cnt_o
);

  logic               hold_valid_q, hold_valid_d;
  logic [WORD_W-1:0]  hold_word_q,  hold_word_d;
  logic [N_BUF-1:0]   guard_q,      guard_d;
  logic [N_BUF-1:0]   valid_q,      valid_d;
  logic [N_BUF-1:0]   direct_q,     direct_d;
  logic [DATA_W-1:0]  data_q,       data_d;
  logic [DELAY_W-1:0] delay_q,      delay_d;
  logic               err_q,        err_d;
  logic [31:0]        cnt_q,        cnt_d;

  logic [DEST_W-1:0]  hold_dest;
  logic               hold_direct;
  logic [RSVD_W-1:0]  hold_rsvd;
  logic [DELAY_W-1:0] hold_delay;
  logic [DATA_W-1:0]  hold_data;

  logic [N_BUF-1:0]   dest_sel;
  logic [N_BUF-1:0]   chan_ok;
  logic               well_formed;
  logic               fifo_ok;
  logic               issue_now;
  logic               drop_now;
  logic               accept;

  assign hold_dest   = hold_word_q[DEST_MSB:DEST_LSB];
  assign hold_direct = hold_word_q[DIRECT_BIT];
  assign hold_rsvd   = hold_word_q[RSVD_MSB:RSVD_LSB];
  assign hold_delay  = hold_word_q[DELAY_MSB:DELAY_LSB];
  assign hold_data   = hold_word_q[DATA_MSB:DATA_LSB];

  // Per-channel decode of the held destination and FIFO-write qualification.
  // guard_q covers the cycle in which a FIFO write is in flight but full_i
  // does not yet reflect it, so a second write to the same channel waits.
  for (genvar k = 0; k < N_BUF; k++) begin : g_chan
    assign dest_sel[k] = (hold_dest == DEST_W'(k));
    assign chan_ok[k]  = !full_i[k] && !guard_q[k];
  end

  assign well_formed = (hold_rsvd == '0) && (32'(hold_dest) < 32'(N_BUF));
  assign fifo_ok     = |(dest_sel & chan_ok);
  assign issue_now   = hold_valid_q && enable_i && well_formed && (hold_direct || fifo_ok);
  // Malformed words are discarded on the first edge after they are taken.
  assign drop_now    = hold_valid_q && !well_formed;

  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign in_ready_o  = rst_n && enable_i && (!hold_valid_q || issue_now || drop_now);
  assign accept      = in_valid_i && in_ready_o;

  // Next-state for the holding register, strobes, shared buses and counter.
  // Accepting on the same edge as an issue overwrites the slot, so a steady
  // stream moves one word per cycle without a bubble.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    valid_d      = '0;
    direct_d     = '0;
    data_d       = data_q;
    delay_d      = delay_q;
    err_d        = drop_now;
    cnt_d        = cnt_q;

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_word_d  = in_data_i;
    end else if (issue_now || drop_now) begin
      hold_valid_d = 1'b0;
    end

    if (issue_now) begin
      data_d  = hold_data;
      delay_d = hold_delay;
      cnt_d   = cnt_q + 32'd1;
      if (hold_direct) begin
        direct_d = dest_sel;
      end else begin
        valid_d  = dest_sel;
      end
    end

    // Direct writes never arm the guard.
    guard_d = valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      guard_q      <= '0;
      valid_q      <= '0;
      direct_q     <= '0;
      data_q       <= '0;
      delay_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      guard_q      <= guard_d;
      valid_q      <= valid_d;
      direct_q     <= direct_d;
      data_q       <= data_d;
      delay_q      <= delay_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign data_o       = data_q;
  assign delay_o      = delay_q;
  assign valid_o      = valid_q;
  assign direct_o     = direct_q;
  assign err_o        = err_q;
  assign issued_cnt_o = cnt_q;

endmodule : flo_dispatch

// File: tb/tb_flo_dispatch.sv
// ---------------------------------------------------------------------------
// tb_flo_dispatch
// Directed testbench for flo_dispatch with N_BUF = 8. Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising
// edge. Expected values are hand-computed constants in each step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_flo_dispatch;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [NB-1:0] full_i;
  logic [15:0] data_o;
  logic [6:0]  delay_o;
  logic [NB-1:0] valid_o;
  logic [NB-1:0] direct_o;
  logic        err_o;
  logic [31:0] issued_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  flo_dispatch #(.N_BUF(NB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .in_data_i    (in_data_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .full_i       (full_i),
    .data_o       (data_o),
    .delay_o      (delay_o),
    .valid_o      (valid_o),
    .direct_o     (direct_o),
    .err_o        (err_o),
    .issued_cnt_o (issued_cnt_o)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Safety net so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive all upstream-facing inputs in one go.
  task automatic applyStimulus(input logic v, input logic [31:0] w,
                               input logic en, input logic [NB-1:0] full);
    in_valid_i = v;
    in_data_i  = w;
    enable_i   = en;
    full_i     = full;
  endtask

  // One immediate-assertion comparison; counts it and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Linear directed sequence; each @(negedge clk) is one cycle.
  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, '0);

    // Reset state: ready held low, all registered outputs cleared.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, in_ready_o}, 32'h0);
    checkOutput("rst_valid", {24'b0, valid_o}, 32'h0);
    checkOutput("rst_cnt", issued_cnt_o, 32'h0);
    checkOutput("rst_data", {16'b0, data_o}, 32'h0);
    rst_n = 1'b1;

    // Two back-to-back FIFO words to channels 0 and 1.
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, '0);
    #1 checkOutput("b2b_ready0", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk);
    checkOutput("b2b_nostrobe", {24'b0, valid_o}, 32'h0);
    applyStimulus(1'b1, 32'h1005_ABCD, 1'b1, '0);
    #1 checkOutput("b2b_ready1", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk);
    checkOutput("b2b_valid0", {24'b0, valid_o}, 32'h01);
    checkOutput("b2b_data0", {16'b0, data_o}, 32'h1234);
    checkOutput("b2b_delay0", {25'b0, delay_o}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, '0);
    @(negedge clk);
    checkOutput("b2b_valid1", {24'b0, valid_o}, 32'h02);
    checkOutput("b2b_data1", {16'b0, data_o}, 32'hABCD);
    checkOutput("b2b_delay1", {25'b0, delay_o}, 32'h5);
    checkOutput("b2b_cnt", issued_cnt_o, 32'd2);
    @(negedge clk);
    checkOutput("b2b_idle", {24'b0, valid_o}, 32'h0);
    checkOutput("b2b_data_hold", {16'b0, data_o}, 32'hABCD);

    // Three FIFO words to channel 3: strobes two cycles apart.
    @(negedge clk);
    applyStimulus(1'b1, 32'h3000_0001, 1'b1, '0);
    @(negedge clk);
    checkOutput("same_v0", {24'b0, valid_o}, 32'h0);
    applyStimulus(1'b1, 32'h3000_0002, 1'b1, '0);
    #1 checkOutput("same_ready_a", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk);
    checkOutput("same_v1", {24'b0, valid_o}, 32'h08);
    checkOutput("same_d1", {16'b0, data_o}, 32'h0001);
    applyStimulus(1'b1, 32'h3000_0003, 1'b1, '0);
    #1 checkOutput("same_guard_ready", {31'b0, in_ready_o}, 32'h0);
    @(negedge clk);
    checkOutput("same_gap1", {24'b0, valid_o}, 32'h0);
    checkOutput("same_ready_b", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk);
    checkOutput("same_v2", {24'b0, valid_o}, 32'h08);
    checkOutput("same_d2", {16'b0, data_o}, 32'h0002);
    applyStimulus(1'b0, 32'h0, 1'b1, '0);
    @(negedge clk);
    checkOutput("same_gap2", {24'b0, valid_o}, 32'h0);
    @(negedge clk);
    checkOutput("same_v3", {24'b0, valid_o}, 32'h08);
    checkOutput("same_d3", {16'b0, data_o}, 32'h0003);
    checkOutput("same_cnt", issued_cnt_o, 32'd5);

    // FIFO word to a full channel 2 stalls until full_i drops.
    @(negedge clk);
    applyStimulus(1'b1, 32'h2000_0042, 1'b1, 8'h04);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h04);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("full_nostrobe", {24'b0, valid_o}, 32'h0);
      checkOutput("full_ready", {31'b0, in_ready_o}, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h00);
    @(negedge clk);
    checkOutput("full_release", {24'b0, valid_o}, 32'h04);
    checkOutput("full_data", {16'b0, data_o}, 32'h0042);
    checkOutput("full_cnt", issued_cnt_o, 32'd6);

    // Direct word to full channel 2 goes straight through.
    @(negedge clk);
    applyStimulus(1'b1, 32'h2800_00FF, 1'b1, 8'h04);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h04);
    #1 checkOutput("dir_ready", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk);
    checkOutput("dir_strobe", {24'b0, direct_o}, 32'h04);
    checkOutput("dir_novalid", {24'b0, valid_o}, 32'h0);
    checkOutput("dir_data", {16'b0, data_o}, 32'h00FF);
    checkOutput("dir_cnt", issued_cnt_o, 32'd7);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h00);

    // Malformed words: dest 9 and reserved bit set.
    @(negedge clk);
    applyStimulus(1'b1, 32'h9000_0001, 1'b1, '0);
    @(negedge clk);
    checkOutput("bad_err_pre", {31'b0, err_o}, 32'h0);
    applyStimulus(1'b1, 32'h0080_0001, 1'b1, '0);
    #1 checkOutput("bad_ready", {31'b0, in_ready_o}, 32'h1);
    @(negedge clk);
    checkOutput("bad_err_dest", {31'b0, err_o}, 32'h1);
    checkOutput("bad_valid_a", {24'b0, valid_o}, 32'h0);
    checkOutput("bad_direct_a", {24'b0, direct_o}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, '0);
    @(negedge clk);
    checkOutput("bad_err_rsvd", {31'b0, err_o}, 32'h1);
    checkOutput("bad_valid_b", {24'b0, valid_o}, 32'h0);
    checkOutput("bad_cnt", issued_cnt_o, 32'd7);
    checkOutput("bad_data_hold", {16'b0, data_o}, 32'h00FF);
    @(negedge clk);
    checkOutput("bad_err_clear", {31'b0, err_o}, 32'h0);

    // Enable dropped with a word held: nothing moves until it returns.
    @(negedge clk);
    applyStimulus(1'b1, 32'h1000_0077, 1'b1, '0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h1000_0088, 1'b0, '0);
    #1 checkOutput("en_ready", {31'b0, in_ready_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("en_hold", {24'b0, valid_o}, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, '0);
    @(negedge clk);
    checkOutput("en_issue", {24'b0, valid_o}, 32'h02);
    checkOutput("en_data", {16'b0, data_o}, 32'h0077);
    checkOutput("en_cnt", issued_cnt_o, 32'd8);

    // Reset asserted mid-stall discards the held word.
    @(negedge clk);
    applyStimulus(1'b1, 32'h4000_0099, 1'b1, 8'h10);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h10);
    @(negedge clk);
    checkOutput("stall_nostrobe", {24'b0, valid_o}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_data", {16'b0, data_o}, 32'h0);
    checkOutput("arst_cnt", issued_cnt_o, 32'h0);
    checkOutput("arst_ready", {31'b0, in_ready_o}, 32'h0);
    checkOutput("arst_delay", {25'b0, delay_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", {24'b0, valid_o}, 32'h0);
      checkOutput("post_rst_cnt", issued_cnt_o, 32'h0);
    end

    // Fresh word after reset issues normally.
    applyStimulus(1'b1, 32'h4003_0011, 1'b1, '0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, '0);
    @(negedge clk);
    checkOutput("post_valid", {24'b0, valid_o}, 32'h10);
    checkOutput("post_data", {16'b0, data_o}, 32'h0011);
    checkOutput("post_delay", {25'b0, delay_o}, 32'h3);
    checkOutput("post_cnt", issued_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_flo_dispatch
